// File: rtl/vector_stream_pkg.sv
// Shared types and constants for the vector stream engine.
package vector_stream_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam int CAP_DELAY_MAX = 15;
   localparam int CNT_W         = 32;

endpackage

// File: rtl/vector_stream_engine_sync_fifo.sv
// Single-clock show-ahead FIFO; full/empty distinguished by an extra pointer MSB.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 512
) (
   input  logic             clk,
   input  logic             logic_reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (logic_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage is deliberately not reset; emptiness comes from the pointers alone.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/vector_stream_engine.sv
// Stimulus playback / result capture engine with a config register bank.
module vector_stream_engine
   import vector_stream_pkg::*;
#(
   parameter int register_size      = 32,
   parameter int register_count     = 32,
   parameter int input_vector_size  = 32,
   parameter int output_vector_size = 32,
   parameter int fifo_depth         = 512,
   parameter int capture_delay      = 1
) (
   input  logic                                    clk,
   input  logic                                    logic_reset,
   input  logic                                    cfg_wr_en,
   input  logic [$clog2(register_count)-1:0]       cfg_addr,
   input  logic [register_size-1:0]                cfg_wr_data,
   output logic [register_size-1:0]                cfg_rd_data,
   output logic [register_count*register_size-1:0] config_flat,
   input  logic                                    stim_valid,
   input  logic [input_vector_size-1:0]            stim_data,
   output logic                                    stim_ready,
   output logic                                    cap_valid,
   output logic [output_vector_size-1:0]           cap_data,
   input  logic                                    cap_ready,
   output logic [input_vector_size-1:0]            input_vector,
   input  logic [output_vector_size-1:0]           output_vector,
   input  logic                                    start,
   input  logic                                    stop,
   input  logic                                    stop_on_empty,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    underrun,
   output logic                                    overflow,
   output logic [CNT_W-1:0]                        cycle_count
);

   localparam int DW = $clog2(CAP_DELAY_MAX + 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(capture_delay);

   logic [register_size-1:0]     config_regs [register_count];
   state_t                       state;
   logic [DW-1:0]                drain_cnt;
   logic [capture_delay:0]       cap_vld;
   logic                         stim_full, stim_empty, stim_pop;
   logic [input_vector_size-1:0] stim_head;
   logic                         cap_full, cap_empty, cap_push;

   always_ff @(posedge clk) begin
      if (logic_reset) begin
         for (int i = 0; i < register_count; i++) config_regs[i] <= '0;
         cfg_rd_data <= '0;
      end else begin
         if (cfg_wr_en) config_regs[cfg_addr] <= cfg_wr_data;
         cfg_rd_data <= config_regs[cfg_addr];
      end
   end

   for (genvar g = 0; g < register_count; g++) begin : g_flat
      assign config_flat[g*register_size +: register_size] = config_regs[g];
   end

   // NOTE: the pop strobe is combinational so the head word lands on input_vector at this same edge.
   assign stim_pop   = (state == RUN) && !stop && !stim_empty;
   assign stim_ready = !stim_full;

   sync_fifo #(.WIDTH(input_vector_size), .DEPTH(fifo_depth)) u_stim_fifo (
      .clk         (clk),
      .logic_reset (logic_reset),
      .push        (stim_valid && !stim_full),
      .push_data   (stim_data),
      .pop         (stim_pop),
      .pop_data    (stim_head),
      .full        (stim_full),
      .empty       (stim_empty)
   );

   // The tail of the valid pipe lines up with the DUT result of the applied word.
   assign cap_push  = cap_vld[capture_delay] && !cap_full;
   assign cap_valid = !cap_empty;

   sync_fifo #(.WIDTH(output_vector_size), .DEPTH(fifo_depth)) u_cap_fifo (
      .clk         (clk),
      .logic_reset (logic_reset),
      .push        (cap_push),
      .push_data   (output_vector),
      .pop         (cap_valid && cap_ready),
      .pop_data    (cap_data),
      .full        (cap_full),
      .empty       (cap_empty)
   );

   always_ff @(posedge clk) begin
      if (logic_reset) begin
         state        <= IDLE;
         input_vector <= '0;
         cycle_count  <= '0;
         drain_cnt    <= '0;
         cap_vld      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         underrun     <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         done       <= 1'b0;
         cap_vld[0] <= stim_pop;
         for (int i = 1; i <= capture_delay; i++) cap_vld[i] <= cap_vld[i-1];
         if (cap_vld[capture_delay] && cap_full) overflow <= 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  state       <= RUN;
                  busy        <= 1'b1;
                  underrun    <= 1'b0;
                  overflow    <= 1'b0;
                  cycle_count <= '0;
               end
            end
            RUN: begin
               if (cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
               if (stop) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end else if (!stim_empty) begin
                  input_vector <= stim_head;
               end else if (stop_on_empty) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end else begin
                  underrun <= 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + DW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
